// File: rtl/spell_rambus_pkg.sv
// rtl/spell_rambus_pkg.sv - shared constants and state encoding for the spell rambus responder
package spell_rambus_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam int RAMBUS_ADDR_W = 10;
    localparam int RAMBUS_DATA_W = 32;
    localparam int RAMBUS_SEL_W  = 4;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_WAIT  = WAIT,
        ST_ACK   = ACK
    } state_t;

endpackage

// File: rtl/spell_rr_arbiter.sv
// rtl/spell_rr_arbiter.sv - two-request round-robin arbiter; last_grant moves only on a grant strobe
module spell_rr_arbiter
    import spell_rambus_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_grant_stb,
    output logic o_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = PORT_A;
        if (i_req_a && i_req_b) begin
            o_grant = ~r_last_grant;
        end else if (i_req_b) begin
            o_grant = PORT_B;
        end
    end

    // Resetting to B lets A win the first tie after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= PORT_B;
        end else if (i_grant_stb) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/spell_rambus_responder.sv
// rtl/spell_rambus_responder.sv - two-port classic Wishbone responder serving one single-port SRAM macro
module spell_rambus_responder
    import spell_rambus_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int WORDS        = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         a_wb_cyc_i,
    input  logic                         a_wb_stb_i,
    input  logic                         a_wb_we_i,
    input  logic [RAMBUS_SEL_W-1:0]      a_wb_sel_i,
    input  logic [RAMBUS_ADDR_W-1:0]     a_wb_addr_i,
    input  logic [RAMBUS_DATA_W-1:0]     a_wb_dat_i,
    output logic                         a_wb_ack_o,
    output logic [RAMBUS_DATA_W-1:0]     a_wb_dat_o,
    input  logic                         b_wb_cyc_i,
    input  logic                         b_wb_stb_i,
    input  logic                         b_wb_we_i,
    input  logic [RAMBUS_SEL_W-1:0]      b_wb_sel_i,
    input  logic [RAMBUS_ADDR_W-1:0]     b_wb_addr_i,
    input  logic [RAMBUS_DATA_W-1:0]     b_wb_dat_i,
    output logic                         b_wb_ack_o,
    output logic [RAMBUS_DATA_W-1:0]     b_wb_dat_o,
    output logic                         sram_csb_o,
    output logic                         sram_web_o,
    output logic [RAMBUS_SEL_W-1:0]      sram_wmask_o,
    output logic [$clog2(WORDS)-1:0]     sram_addr_o,
    output logic [RAMBUS_DATA_W-1:0]     sram_din_o,
    input  logic [RAMBUS_DATA_W-1:0]     sram_dout_i
);

    localparam int         WADDR_W  = $clog2(WORDS);
    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_port;
    logic                       r_we;
    logic [1:0]                 r_wait_cnt;
    logic                       r_csb;
    logic                       r_web;
    logic [RAMBUS_SEL_W-1:0]    r_wmask;
    logic [WADDR_W-1:0]         r_addr;
    logic [RAMBUS_DATA_W-1:0]   r_din;
    logic [RAMBUS_DATA_W-1:0]   r_a_dat;
    logic [RAMBUS_DATA_W-1:0]   r_b_dat;

    logic                       w_req_a;
    logic                       w_req_b;
    logic                       w_grant;
    logic                       w_grant_stb;
    logic                       w_wait_done;
    logic                       w_we;
    logic [RAMBUS_SEL_W-1:0]    w_sel;
    logic [WADDR_W-1:0]         w_addr;
    logic [RAMBUS_DATA_W-1:0]   w_dat;
    logic                       w_unused_addr_lsbs;

    assign w_req_a     = a_wb_cyc_i & a_wb_stb_i;
    assign w_req_b     = b_wb_cyc_i & b_wb_stb_i;
    assign w_grant_stb = (r_state == ST_IDLE) && (w_req_a || w_req_b);
    assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == LAST_CNT);

    assign w_we   = (w_grant == PORT_B) ? b_wb_we_i : a_wb_we_i;
    assign w_sel  = (w_grant == PORT_B) ? b_wb_sel_i : a_wb_sel_i;
    assign w_addr = (w_grant == PORT_B) ? b_wb_addr_i[2 +: WADDR_W] : a_wb_addr_i[2 +: WADDR_W];
    assign w_dat  = (w_grant == PORT_B) ? b_wb_dat_i : a_wb_dat_i;
    assign w_unused_addr_lsbs = ^{a_wb_addr_i[1:0], b_wb_addr_i[1:0]};

    spell_rr_arbiter u_arbiter (
        .clock       (clock),
        .reset       (reset),
        .i_req_a     (w_req_a),
        .i_req_b     (w_req_b),
        .i_grant_stb (w_grant_stb),
        .o_grant     (w_grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_a || w_req_b) w_next = ST_ISSUE;
            ST_ISSUE: w_next = r_we ? ST_ACK : ST_WAIT;
            ST_WAIT:  if (w_wait_done) w_next = ST_ACK;
            ST_ACK:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // SRAM controls are loaded at the grant edge so the macro sees them during ISSUE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_port     <= PORT_A;
            r_we       <= 1'b0;
            r_wait_cnt <= 2'd0;
            r_csb      <= 1'b1;
            r_web      <= 1'b1;
            r_wmask    <= '0;
            r_addr     <= '0;
            r_din      <= '0;
            r_a_dat    <= '0;
            r_b_dat    <= '0;
        end else begin
            r_csb <= 1'b1;
            r_web <= 1'b1;
            if (w_grant_stb) begin
                r_port  <= w_grant;
                r_we    <= w_we;
                r_csb   <= w_we && (w_sel == '0);
                r_web   <= ~w_we;
                r_wmask <= w_sel;
                r_addr  <= w_addr;
                r_din   <= w_dat;
            end
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= 2'd0;
            end else if (r_state == ST_WAIT && r_wait_cnt != 2'd3) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
            if (w_wait_done) begin
                if (r_port == PORT_A) r_a_dat <= sram_dout_i;
                else                  r_b_dat <= sram_dout_i;
            end
        end
    end

    // A dropped cyc in ACK turns the transfer into a silent abort.
    assign a_wb_ack_o   = (r_state == ST_ACK) && (r_port == PORT_A) && a_wb_cyc_i;
    assign b_wb_ack_o   = (r_state == ST_ACK) && (r_port == PORT_B) && b_wb_cyc_i;
    assign a_wb_dat_o   = r_a_dat;
    assign b_wb_dat_o   = r_b_dat;
    assign sram_csb_o   = r_csb;
    assign sram_web_o   = r_web;
    assign sram_wmask_o = r_wmask;
    assign sram_addr_o  = r_addr;
    assign sram_din_o   = r_din;

endmodule

// File: tb/tb_spell_rambus_responder.sv
// tb/tb_spell_rambus_responder.sv - directed self-checking bench for spell_rambus_responder
module tb_spell_rambus_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [3:0]  a_sel, b_sel;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_dat, b_dat;
    logic        a_ack, b_ack;
    logic [31:0] a_dato, b_dato;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [7:0]  saddr;
    logic [31:0] din, dout;

    logic        c_cyc, c_stb, c_we, d_cyc, d_stb, d_we;
    logic [3:0]  c_sel, d_sel;
    logic [9:0]  c_addr, d_addr;
    logic [31:0] c_dat, d_dat;
    logic        c_ack, d_ack;
    logic [31:0] c_dato, d_dato;
    logic        s3_csb, s3_web;
    logic [3:0]  s3_wmask;
    logic [7:0]  s3_addr;
    logic [31:0] s3_din, s3_dout;

    int total = 0;
    int bad = 0;
    int dual_cnt = 0;

    spell_rambus_responder #(.READ_LATENCY(1), .WORDS(256)) dut1 (
        .clock(clock), .reset(reset),
        .a_wb_cyc_i(a_cyc), .a_wb_stb_i(a_stb), .a_wb_we_i(a_we), .a_wb_sel_i(a_sel),
        .a_wb_addr_i(a_addr), .a_wb_dat_i(a_dat), .a_wb_ack_o(a_ack), .a_wb_dat_o(a_dato),
        .b_wb_cyc_i(b_cyc), .b_wb_stb_i(b_stb), .b_wb_we_i(b_we), .b_wb_sel_i(b_sel),
        .b_wb_addr_i(b_addr), .b_wb_dat_i(b_dat), .b_wb_ack_o(b_ack), .b_wb_dat_o(b_dato),
        .sram_csb_o(csb), .sram_web_o(web), .sram_wmask_o(wmask), .sram_addr_o(saddr),
        .sram_din_o(din), .sram_dout_i(dout)
    );

    spell_rambus_responder #(.READ_LATENCY(3), .WORDS(256)) dut3 (
        .clock(clock), .reset(reset),
        .a_wb_cyc_i(c_cyc), .a_wb_stb_i(c_stb), .a_wb_we_i(c_we), .a_wb_sel_i(c_sel),
        .a_wb_addr_i(c_addr), .a_wb_dat_i(c_dat), .a_wb_ack_o(c_ack), .a_wb_dat_o(c_dato),
        .b_wb_cyc_i(d_cyc), .b_wb_stb_i(d_stb), .b_wb_we_i(d_we), .b_wb_sel_i(d_sel),
        .b_wb_addr_i(d_addr), .b_wb_dat_i(d_dat), .b_wb_ack_o(d_ack), .b_wb_dat_o(d_dato),
        .sram_csb_o(s3_csb), .sram_web_o(s3_web), .sram_wmask_o(s3_wmask), .sram_addr_o(s3_addr),
        .sram_din_o(s3_din), .sram_dout_i(s3_dout)
    );

    // SRAM models: read data is only meaningful in its valid cycle, garbage otherwise.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] p1;
    logic        v1 = 1'b0;
    logic [31:0] p3 [3];
    logic [2:0]  v3 = 3'b000;

    always @(posedge clock) begin
        v1 <= 1'b0;
        if (!csb) begin
            if (!web) begin
                for (int i = 0; i < 4; i++)
                    if (wmask[i]) mem1[saddr][i*8 +: 8] <= din[i*8 +: 8];
            end else begin
                p1 <= mem1[saddr];
                v1 <= 1'b1;
            end
        end
    end
    assign dout = v1 ? p1 : 32'hBAD0BAD0;

    always @(posedge clock) begin
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        v3    <= {v3[1:0], 1'b0};
        if (!s3_csb && s3_web) begin
            p3[0] <= mem3[s3_addr];
            v3[0] <= 1'b1;
        end
    end
    assign s3_dout = v3[2] ? p3[2] : 32'hBAD0BAD0;

    always @(negedge clock) if (a_ack && b_ack) dual_cnt++;

    task automatic xfer(input bit port, input bit we, input logic [3:0] sel, input logic [9:0] addr,
                        input logic [31:0] dat, output int ack_cyc, output int csb_cnt,
                        output int csb_cyc, output logic web_s, output logic [7:0] addr_s,
                        output logic [3:0] mask_s, output logic [31:0] rdat);
        @(posedge clock); #1;
        if (port) begin b_cyc = 1; b_stb = 1; b_we = we; b_sel = sel; b_addr = addr; b_dat = dat; end
        else      begin a_cyc = 1; a_stb = 1; a_we = we; a_sel = sel; a_addr = addr; a_dat = dat; end
        ack_cyc = -1; csb_cnt = 0; csb_cyc = -1; web_s = 1'bx; addr_s = 'x; mask_s = 'x; rdat = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!csb) begin
                csb_cnt++; csb_cyc = k; web_s = web; addr_s = saddr; mask_s = wmask;
            end
            if (port ? b_ack : a_ack) begin
                ack_cyc = k; rdat = port ? b_dato : a_dato;
                break;
            end
        end
        @(posedge clock); #1;
        if (port) begin b_cyc = 0; b_stb = 0; end
        else      begin a_cyc = 0; a_stb = 0; end
    endtask

    task automatic test_reset();
        total++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b exp=00", a_ack, b_ack); end
        total++; if (a_dato !== 32'h0 || b_dato !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h/%h exp=0", a_dato, b_dato); end
        total++; if (csb !== 1'b1 || web !== 1'b1) begin bad++; $display("FAIL reset_csb_web got=%b%b exp=11", csb, web); end
        total++; if (wmask !== 4'h0 || saddr !== 8'h0 || din !== 32'h0) begin bad++; $display("FAIL reset_sram got=%h/%h/%h exp=0", wmask, saddr, din); end
    endtask

    task automatic test_write_read_a();
        int ack, cnt, cc; logic w; logic [7:0] ad; logic [3:0] m; logic [31:0] rd;
        xfer(0, 1, 4'hF, 10'h004, 32'hDEADBEEF, ack, cnt, cc, w, ad, m, rd);
        total++; if (cc !== 1 || cnt !== 1) begin bad++; $display("FAIL a_wr_csb got=cyc%0d n%0d exp=cyc1 n1", cc, cnt); end
        total++; if (w !== 1'b0 || ad !== 8'h01 || m !== 4'hF) begin bad++; $display("FAIL a_wr_ctrl got=%b/%h/%h exp=0/01/f", w, ad, m); end
        total++; if (ack !== 2) begin bad++; $display("FAIL a_wr_ack got=%0d exp=2", ack); end
        total++; if (mem1[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL a_wr_mem got=%h exp=deadbeef", mem1[1]); end
        xfer(0, 0, 4'hF, 10'h004, 32'h0, ack, cnt, cc, w, ad, m, rd);
        total++; if (cc !== 1 || w !== 1'b1) begin bad++; $display("FAIL a_rd_csb got=cyc%0d web%b exp=cyc1 web1", cc, w); end
        total++; if (ack !== 3) begin bad++; $display("FAIL a_rd_ack got=%0d exp=3", ack); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL a_rd_dat got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_byte_mask_b();
        int ack, cnt, cc; logic w; logic [7:0] ad; logic [3:0] m; logic [31:0] rd;
        mem1[16] = 32'h11223344;
        xfer(1, 1, 4'b0001, 10'h040, 32'h000000AA, ack, cnt, cc, w, ad, m, rd);
        total++; if (ack !== 2 || m !== 4'b0001 || ad !== 8'h10) begin bad++; $display("FAIL b_mask_wr got=ack%0d %h/%h exp=ack2 1/10", ack, m, ad); end
        xfer(1, 0, 4'hF, 10'h040, 32'h0, ack, cnt, cc, w, ad, m, rd);
        total++; if (ack !== 3 || rd !== 32'h112233AA) begin bad++; $display("FAIL b_mask_rd got=ack%0d %h exp=ack3 112233aa", ack, rd); end
        xfer(1, 1, 4'b0000, 10'h040, 32'hFFFFFFFF, ack, cnt, cc, w, ad, m, rd);
        total++; if (cnt !== 0) begin bad++; $display("FAIL b_sel0_csb got=%0d exp=0", cnt); end
        total++; if (ack !== 2) begin bad++; $display("FAIL b_sel0_ack got=%0d exp=2", ack); end
        total++; if (mem1[16] !== 32'h112233AA) begin bad++; $display("FAIL b_sel0_mem got=%h exp=112233aa", mem1[16]); end
        total++; if (a_dato !== 32'hDEADBEEF) begin bad++; $display("FAIL a_dat_hold got=%h exp=deadbeef", a_dato); end
    endtask

    task automatic test_latency3();
        int ack = -1; int cnt = 0; int cc = -1; logic [31:0] at4 = 'x; logic [31:0] rd = 'x;
        mem3[5] = 32'hCAFEF00D;
        @(posedge clock); #1;
        c_cyc = 1; c_stb = 1; c_we = 0; c_sel = 4'hF; c_addr = 10'h014;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!s3_csb) begin cnt++; cc = k; end
            if (k == 4) at4 = c_dato;
            if (c_ack) begin ack = k; rd = c_dato; break; end
        end
        @(posedge clock); #1; c_cyc = 0; c_stb = 0;
        total++; if (cc !== 1 || cnt !== 1) begin bad++; $display("FAIL l3_csb got=cyc%0d n%0d exp=cyc1 n1", cc, cnt); end
        total++; if (ack !== 5) begin bad++; $display("FAIL l3_ack got=%0d exp=5", ack); end
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL l3_dat got=%h exp=cafef00d", rd); end
        total++; if (at4 !== 32'h0) begin bad++; $display("FAIL l3_dat_early got=%h exp=0", at4); end
    endtask

    task automatic test_reset_mid();
        int ack, cnt, cc; logic w; logic [7:0] ad; logic [3:0] m; logic [31:0] rd;
        int acks = 0;
        @(posedge clock); #1;
        a_cyc = 1; a_stb = 1; a_we = 0; a_sel = 4'hF; a_addr = 10'h040;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (a_ack) acks++;
        end
        reset = 1;
        @(negedge clock);
        total++; if (csb !== 1'b1 || a_ack !== 1'b0 || b_ack !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got=%b%b%b exp=100", csb, a_ack, b_ack); end
        total++; if (a_dato !== 32'h0 || b_dato !== 32'h0) begin bad++; $display("FAIL rst_mid_dat got=%h/%h exp=0", a_dato, b_dato); end
        reset = 0; a_cyc = 0; a_stb = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (a_ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rst_mid_noack got=%0d exp=0", acks); end
        xfer(0, 1, 4'hF, 10'h00C, 32'h01020304, ack, cnt, cc, w, ad, m, rd);
        total++; if (ack !== 2 || mem1[3] !== 32'h01020304) begin bad++; $display("FAIL rst_mid_wr got=ack%0d %h exp=ack2 01020304", ack, mem1[3]); end
    endtask

    task automatic test_arbitration();
        int ports [4]; int at [4]; int n = 0;
        int exp_at [4] = '{2, 5, 8, 11};
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        dual_cnt = 0;
        @(posedge clock); #1;
        a_cyc = 1; a_stb = 1; a_we = 1; a_sel = 4'hF; a_addr = 10'h008; a_dat = 32'h1;
        b_cyc = 1; b_stb = 1; b_we = 1; b_sel = 4'hF; b_addr = 10'h00C; b_dat = 32'h2;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge clock);
            if (a_ack && n < 4) begin ports[n] = 0; at[n] = k; n++; end
            if (b_ack && n < 4) begin ports[n] = 1; at[n] = k; n++; end
        end
        @(posedge clock); #1;
        a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0;
        total++; if (n !== 4) begin bad++; $display("FAIL arb_count got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (ports[i] !== (i % 2) || at[i] !== exp_at[i]) begin
                bad++; $display("FAIL arb_order[%0d] got=port%0d cyc%0d exp=port%0d cyc%0d", i, ports[i], at[i], i % 2, exp_at[i]);
            end
        end
        total++; if (dual_cnt !== 0) begin bad++; $display("FAIL arb_dual_ack got=%0d exp=0", dual_cnt); end
        total++; if (mem1[2] !== 32'h1 || mem1[3] !== 32'h2) begin bad++; $display("FAIL arb_mem got=%h/%h exp=1/2", mem1[2], mem1[3]); end
    endtask

    task automatic test_abort();
        int a_acks = 0; int b_at = -1; int cc = -1; int cnt = 0;
        mem1[40] = 32'h5A5A0001;
        @(posedge clock); #1;
        a_cyc = 1; a_stb = 1; a_we = 0; a_sel = 4'hF; a_addr = 10'h0A0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (a_ack) a_acks++;
            if (!csb) begin cnt++; cc = k; end
            if (b_ack) begin b_at = k; break; end
            if (k == 1) begin b_cyc = 1; b_stb = 1; b_we = 1; b_sel = 4'hF; b_addr = 10'h010; b_dat = 32'h77; end
            if (k == 2) begin a_cyc = 0; a_stb = 0; end
        end
        @(posedge clock); #1; b_cyc = 0; b_stb = 0;
        total++; if (a_acks !== 0) begin bad++; $display("FAIL abort_a_ack got=%0d exp=0", a_acks); end
        total++; if (b_at !== 6) begin bad++; $display("FAIL abort_b_ack got=%0d exp=6", b_at); end
        total++; if (cc !== 5 || cnt !== 2) begin bad++; $display("FAIL abort_csb got=cyc%0d n%0d exp=cyc5 n2", cc, cnt); end
        total++; if (a_dato !== 32'h5A5A0001) begin bad++; $display("FAIL abort_dat got=%h exp=5a5a0001", a_dato); end
        total++; if (mem1[4] !== 32'h77) begin bad++; $display("FAIL abort_b_mem got=%h exp=77", mem1[4]); end
    endtask

    initial begin
        a_cyc = 0; a_stb = 0; a_we = 0; a_sel = 0; a_addr = 0; a_dat = 0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_sel = 0; b_addr = 0; b_dat = 0;
        c_cyc = 0; c_stb = 0; c_we = 0; c_sel = 0; c_addr = 0; c_dat = 0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = 0; d_addr = 0; d_dat = 0;
        for (int i = 0; i < 256; i++) begin mem1[i] = 32'h0; mem3[i] = 32'h0; end
        repeat (3) @(posedge clock);
        @(negedge clock);
        test_reset();
        reset = 0;
        test_write_read_a();
        test_byte_mask_b();
        test_latency3();
        test_reset_mid();
        test_arbitration();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spell_rambus_responder.md
# spell_rambus_responder

Wishbone responder at the far end of the spell rambus: accepts classic-Wishbone single transfers from two initiators (port A: spell core rambus master, port B: host/management wishbone) and serves them from one single-port OpenRAM-style SRAM macro. Two-way round-robin arbitration, byte-masked writes, a configurable SRAM read latency, and one-cycle ack pulses. It sits beside the spell core in the user area and owns the shared 1 KB code/data RAM.

## Interface
Parameters:
- READ_LATENCY, 1, cycles from the SRAM sampling edge to valid `sram_dout_i`; legal range 1..4
- WORDS, 256, SRAM depth in 32-bit words; the word address is 8 bits

Ports:
- clock  in  1  system clock; the SRAM macro uses the same clock
- reset  in  1  synchronous, active-high
- a_wb_cyc_i, a_wb_stb_i, a_wb_we_i  in  1 each  port A cycle, strobe, write enable
- a_wb_sel_i  in  4  port A byte selects
- a_wb_addr_i  in  10  port A byte address; bits [9:2] are the word index, bits [1:0] are ignored
- a_wb_dat_i  in  32  port A write data
- a_wb_ack_o  out  1  port A ack, one-cycle pulse
- a_wb_dat_o  out  32  port A read data
- b_wb_*: port B, same set of signals, widths and meanings as port A
- sram_csb_o  out  1  chip select, active-low
- sram_web_o  out  1  write enable, active-low
- sram_wmask_o  out  4  byte write mask
- sram_addr_o  out  8  word address
- sram_din_o  out  32  write data
- sram_dout_i  in  32  read data

## Operation
- Request on a port: cyc_i & stb_i.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE
  - No request: stay in IDLE.
  - One requesting port: grant it.
  - Both ports requesting: grant the port that was not the last one granted. last_grant resets to B, so A wins the first tie.
  - On grant, latch the port ID, we, sel, addr[9:2] and dat, then go to ISSUE.
- ISSUE (one cycle)
  - Drive csb=0, web=!we, wmask=sel, addr, din from the latched values. All SRAM outputs are registered.
  - Write with sel=4'b0000: csb stays 1, no SRAM access, but the transfer is still acked.
  - Write goes to ACK. Read goes to WAIT.
- WAIT
  - Count READ_LATENCY cycles.
  - On the last count, capture `sram_dout_i` into the granted port's dat_o register, then go to ACK.
- ACK (one cycle)
  - Drive the granted port's ack_o=1 only if its cyc_i is still high. Otherwise the transfer completes silently (abort).
  - Go to IDLE.
  - The initiator drops stb after seeing ack, so IDLE never re-serves the same transfer.
- Both ack_o are never high in the same cycle. An ungranted port sees ack=0 and keeps its request pending.
- dat_o of each port holds its last read value until that port's next read completes. Writes leave dat_o unchanged.
- Aborted writes (cyc dropped after grant) are still performed on the SRAM. Aborted reads update dat_o but produce no ack.
- Reset values:
  - State IDLE, last_grant=B.
  - a/b_wb_ack_o=0, a/b_wb_dat_o=0.
  - sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_din_o=0.
- Reset mid-transfer: return to IDLE the next cycle with csb=1. No ack is issued and the in-flight transfer is dropped.

## Timing
- Cycle numbering: the request is first visible in cycle 0.
- Write: csb=0 in cycle 1; ack in cycle 2.
- Read: csb=0 in cycle 1; dout valid in cycle 1+READ_LATENCY; ack and valid dat_o in cycle 2+READ_LATENCY. With READ_LATENCY=1 the ack is in cycle 3.
- Back-to-back: the next grant is evaluated in the IDLE cycle that follows ACK. Peak rate is one write per 3 cycles and one read per 3+READ_LATENCY cycles.
- sram_csb_o is low for exactly one cycle per served non-empty transfer.
- Wait counter: 2 bits, saturating.

## Structure
- Package `spell_rambus_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3);
  - RAMBUS_ADDR_W=10, RAMBUS_DATA_W=32, RAMBUS_SEL_W=4;
  - port ID constants PORT_A=1'b0, PORT_B=1'b1.
- Sub-module `spell_rr_arbiter`: two-request round-robin arbiter with grant and last_grant register, updated only on a grant strobe from IDLE.

## Test plan
- Port A writes 0xDEADBEEF to byte address 0x004 with sel=4'hF, then reads 0x004. Expect csb=0/web=0/addr=8'h01/wmask=4'hF in cycle 1, ack in cycle 2; the read acks in cycle 3 (READ_LATENCY=1) with a_wb_dat_o=0xDEADBEEF.
- Port B writes 0x000000AA with sel=4'b0001 to word 0x10 preloaded with 0x11223344. A read then returns 0x112233AA. With sel=0 there is no csb pulse but ack still arrives in cycle 2.
- A and B request in the same cycle right after reset. A is served first, then B. Repeated simultaneous requests alternate B, A, B. There is never a dual ack.
- READ_LATENCY=3: the read ack arrives in cycle 5, and dout is sampled in cycle 4 only.
- Port A read is granted, then cyc drops during WAIT. Expect no a_wb_ack_o, the FSM back in IDLE, and a pending port B request served next.
- Reset asserted during WAIT. Next cycle: state IDLE, csb=1, both ack=0, both dat_o=0. A subsequent write completes normally.
